// File: rtl/timer_sequencer.sv
// timer_sequencer
//   Avalon-MM master that programs and services a 16-bit-register interval
//   timer (s1 slave). A start command loads a 32-bit period, runs the timer
//   in continuous mode with interrupt enabled, clears status on each irq,
//   and halts the timer after the programmed number of timeouts (or abort).
//
// Ports
//   clk, reset          system clock, synchronous active-high reset
//   start, abort        single-cycle requests (start only honoured in IDLE)
//   cfg_period          timer period; timer fires every cfg_period+1 clocks
//   cfg_count           timeouts to service; 0 = run until abort
//   busy                high in every state except IDLE
//   done                one-cycle pulse when a sequence ends
//   aborted             sequence ended by abort (cleared on next start)
//   tick                one-cycle pulse per serviced timeout
//   event_count         timeouts serviced in current/last sequence
//   tmr_*               registered Avalon-MM master to the timer
//   snapshot            (TIMER_SEQUENCER_SNAPSHOT_EN only) latest counter
//                       snapshot read back after each serviced timeout
//
// Optional feature macro: TIMER_SEQUENCER_SNAPSHOT_EN
module timer_sequencer #(
  parameter int         CNT_W     = 16,
  parameter logic [3:0] CTRL_RUN  = 4'b0111,
  parameter logic [3:0] CTRL_HALT = 4'b1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [31:0]      cfg_period,
  input  logic [CNT_W-1:0] cfg_count,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic             tick,
  output logic [CNT_W-1:0] event_count,
  output logic [2:0]       tmr_address,
  output logic             tmr_chipselect,
  output logic             tmr_write_n,
  output logic [15:0]      tmr_writedata,
  input  logic [15:0]      tmr_readdata,
`ifdef TIMER_SEQUENCER_SNAPSHOT_EN
  output logic [31:0]      snapshot,
`endif
  input  logic             tmr_irq
);

  typedef enum logic [3:0] {
    S_IDLE, S_WR_PL, S_WR_PH, S_WR_RUN, S_WAIT_IRQ, S_CLR, S_WR_HALT, S_DONE,
    S_SNAP_TRIG, S_SNAP_RDL, S_SNAP_RDH, S_SNAP_CAP
  } state_t;

  state_t           state, state_nxt;
  logic [31:0]      period_q;
  logic [CNT_W-1:0] count_q;
  logic             can_abort;
  logic             last_evt;
`ifdef TIMER_SEQUENCER_SNAPSHOT_EN
  logic [15:0]      snap_lo;
`endif

  // Abort is honoured everywhere a sequence is live except once the halt
  // write is already under way.
  assign can_abort = (state != S_IDLE) && (state != S_WR_HALT) && (state != S_DONE);
  // In CLR event_count already holds the incremented count.
  assign last_evt  = (count_q != '0) && (event_count == count_q);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (start && !abort) state_nxt = S_WR_PL;
      S_WR_PL:     state_nxt = S_WR_PH;
      S_WR_PH:     state_nxt = S_WR_RUN;
      S_WR_RUN:    state_nxt = S_WAIT_IRQ;
      S_WAIT_IRQ:  if (tmr_irq) state_nxt = S_CLR;
`ifdef TIMER_SEQUENCER_SNAPSHOT_EN
      S_CLR:       state_nxt = last_evt ? S_WR_HALT : S_SNAP_TRIG;
      S_SNAP_TRIG: state_nxt = S_SNAP_RDL;
      S_SNAP_RDL:  state_nxt = S_SNAP_RDH;
      S_SNAP_RDH:  state_nxt = S_SNAP_CAP;
      S_SNAP_CAP:  state_nxt = S_WAIT_IRQ;
`else
      S_CLR:       state_nxt = last_evt ? S_WR_HALT : S_WAIT_IRQ;
`endif
      S_WR_HALT:   state_nxt = S_DONE;
      S_DONE:      state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
    if (abort && can_abort) state_nxt = S_WR_HALT;
  end

  // All outputs are registered from the next state so the bus access for a
  // state is on the wires for exactly the cycle spent in that state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      period_q       <= '0;
      count_q        <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      aborted        <= 1'b0;
      tick           <= 1'b0;
      event_count    <= '0;
      tmr_address    <= '0;
      tmr_chipselect <= 1'b0;
      tmr_write_n    <= 1'b1;
      tmr_writedata  <= '0;
`ifdef TIMER_SEQUENCER_SNAPSHOT_EN
      snap_lo        <= '0;
      snapshot       <= '0;
`endif
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != S_IDLE);
      done  <= (state_nxt == S_DONE);
      tick  <= (state_nxt == S_CLR);

      if (state == S_IDLE && state_nxt == S_WR_PL) begin
        period_q    <= cfg_period;
        count_q     <= cfg_count;
        event_count <= '0;
        aborted     <= 1'b0;
      end
      if (state_nxt == S_CLR) event_count <= event_count + CNT_W'(1);
      if (abort && can_abort) aborted <= 1'b1;

      tmr_chipselect <= 1'b0;
      tmr_write_n    <= 1'b1;
      tmr_address    <= '0;
      tmr_writedata  <= '0;
      case (state_nxt)
        // Only reachable from IDLE, so the live cfg_period is the value latched.
        S_WR_PL: begin
          tmr_chipselect <= 1'b1; tmr_write_n <= 1'b0;
          tmr_address <= 3'd2; tmr_writedata <= cfg_period[15:0];
        end
        S_WR_PH: begin
          tmr_chipselect <= 1'b1; tmr_write_n <= 1'b0;
          tmr_address <= 3'd3; tmr_writedata <= period_q[31:16];
        end
        S_WR_RUN: begin
          tmr_chipselect <= 1'b1; tmr_write_n <= 1'b0;
          tmr_address <= 3'd1; tmr_writedata <= {12'b0, CTRL_RUN};
        end
        S_CLR: begin
          tmr_chipselect <= 1'b1; tmr_write_n <= 1'b0;
        end
        S_WR_HALT: begin
          tmr_chipselect <= 1'b1; tmr_write_n <= 1'b0;
          tmr_address <= 3'd1; tmr_writedata <= {12'b0, CTRL_HALT};
        end
`ifdef TIMER_SEQUENCER_SNAPSHOT_EN
        S_SNAP_TRIG: begin
          tmr_chipselect <= 1'b1; tmr_write_n <= 1'b0;
          tmr_address <= 3'd4;
        end
        S_SNAP_RDL: begin
          tmr_chipselect <= 1'b1; tmr_address <= 3'd4;
        end
        S_SNAP_RDH: begin
          tmr_chipselect <= 1'b1; tmr_address <= 3'd5;
        end
`endif
        default: ;
      endcase

`ifdef TIMER_SEQUENCER_SNAPSHOT_EN
      // Read data trails the address by one cycle.
      if (state == S_SNAP_RDH) snap_lo  <= tmr_readdata;
      if (state == S_SNAP_CAP) snapshot <= {tmr_readdata, snap_lo};
`endif
    end
  end

endmodule

// File: doc/timer_sequencer.md
Name: timer_sequencer

Overview:
- Avalon-MM master that programs and services the 16-bit-register interval timer on its s1 slave.
- On a start command: loads a 32-bit period, starts the timer in continuous mode with interrupt enabled, and services a programmed number of timeouts by clearing status on each irq.
- After the last serviced timeout it halts the timer.
- Sits between the control logic and the timer, so the timer needs no CPU intervention for burst-timed sequences.

Parameters:
- CNT_W, 16: width of the timeout count and event counter.
- CTRL_RUN, 4'b0111: control word for start (ITO | CONT | START).
- CTRL_HALT, 4'b1000: control word for stop (STOP).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request; accepted only in IDLE.
- abort  in  1  single-cycle request; halts an active sequence.
- cfg_period  in  32  timer period; timer fires every cfg_period+1 clocks.
- cfg_count  in  CNT_W  number of timeouts to service; 0 = run until abort.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on sequence end, normal or aborted.
- aborted  out  1  set when a sequence ends by abort; cleared on next accepted start.
- tick  out  1  one-cycle pulse per serviced timeout.
- event_count  out  CNT_W  timeouts serviced in the current or last sequence.
- tmr_address  out  3  timer register address.
- tmr_chipselect  out  1  timer chipselect.
- tmr_write_n  out  1  timer write strobe, active low.
- tmr_writedata  out  16  timer write data.
- tmr_readdata  in  16  timer read data; registered, valid one cycle after the address.
- tmr_irq  in  1  timer interrupt.

Behaviour:
- Reset (synchronous, active-high) values:
  - State = IDLE.
  - busy = 0, done = 0, aborted = 0, tick = 0, event_count = 0.
  - tmr_chipselect = 0, tmr_write_n = 1, tmr_address = 0, tmr_writedata = 0.
  - Reset mid-sequence aborts with no halt write; the timer keeps its own state.
- Bus outputs are registered. The timer has no waitrequest, so every access occupies exactly one cycle.
- When not accessing: chipselect = 0, write_n = 1, address and writedata = 0.
- State sequence, where T is the cycle in which start is sampled high in IDLE:
  - IDLE: on start (and no abort), latch cfg_period and cfg_count, clear event_count and aborted.
  - T+1 WR_PL: write addr 2 with period[15:0].
  - T+2 WR_PH: write addr 3 with period[31:16].
  - T+3 WR_RUN: write addr 1 with {12'b0, CTRL_RUN}.
  - WAIT_IRQ: bus idle; on tmr_irq = 1 go to CLR.
  - CLR: write addr 0 with data 0; tick = 1; event_count increments (wraps at 2^CNT_W).
    - If cfg_count != 0 and the new count equals cfg_count, go to WR_HALT.
    - Otherwise go to WAIT_IRQ, or the snapshot states when enabled.
  - WR_HALT: write addr 1 with {12'b0, CTRL_HALT}.
  - DONE: done = 1 for one cycle, then IDLE.
- tmr_irq falls the cycle after CLR, so WAIT_IRQ never double-counts one event.
- Abort:
  - Sampled in any busy state other than WR_HALT or DONE: next state is WR_HALT; aborted set at WR_HALT.
  - Abort in IDLE is ignored. If start and abort are both high in IDLE, abort wins and the sequence is not started.
  - Abort sampled while in CLR: that tick still counts.
- start while busy is ignored.
- cfg_* changes after start have no effect until the next start.
- cfg_period < 8 is unsupported; events may be merged.

Optional Feature:
- Macro: TIMER_SEQUENCER_SNAPSHOT_EN.
- When defined:
  - Adds output snapshot [31:0], reset 0.
  - After CLR (when not ending), three extra states run before WAIT_IRQ:
    - SNAP_TRIG: write addr 4, data 0.
    - SNAP_RDL: read addr 4 (chipselect = 1, write_n = 1).
    - SNAP_RDH: read addr 5; capture tmr_readdata as the low half.
  - Then one capture cycle latches tmr_readdata as the high half and updates snapshot.
  - Abort during these states goes to WR_HALT.
- When not defined: no snapshot port, and CLR goes directly to WAIT_IRQ.

Test Plan:
- Basic sequence: cfg_period = 0x0001_0005, start -> writes in order addr2 = 0x0005, addr3 = 0x0001, addr1 = 0x0007 on cycles T+1..T+3.
- Counted run: cfg_period = 19, cfg_count = 3, start -> tick pulses 20 clocks apart; event_count = 3; addr1 = 0x0008 write; done pulse; busy low; aborted = 0.
- Free-run with abort: cfg_count = 0, abort after 5 ticks -> halt write addr1 = 0x0008 next cycle; done; aborted = 1; event_count = 5.
- Start and abort together in IDLE -> no bus activity, busy stays 0. start while busy -> ignored, write sequence unchanged.
- Reset in WAIT_IRQ -> all outputs at reset values the next cycle; new start rewrites period correctly.
- Snapshot (macro on): cfg_period = 99 -> snapshot ~ 99 − 3 each event; addr4 write followed by reads of addr4 and addr5.
